sipo_deser: RTL and testbench
=============================

// Module: sipo_deser
// PURPOSE
//   Serial-in parallel-out deserializer; receive-side counterpart of the 4-bit PISO shifter.
//   Collects WIDTH serial bits, MSB first, qualified by shift, into a word.
//   Presents each completed word on a registered output with a valid/ready handshake.
//   Flags overrun when a word completes while the previous one is still unaccepted.
// PARAMETERS
//   WIDTH  4  bits per word; legal range >= 2
// PORTS
//   clk        in   1                clock; all state updates on rising edge
//   rst        in   1                asynchronous, active-low reset
//   shift      in   1                1 = sample sin this cycle
//   sin        in   1                serial data bit, MSB of word first
//   clr        in   1                sync clear: aborts partial word, clears overrun
//   out_ready  in   1                consumer accepts dout when out_valid=1
//   dout       out  WIDTH            completed word; held stable while out_valid=1
//   out_valid  out  1                dout holds an unaccepted word
//   overrun    out  1                sticky: a completed word was dropped
//   bit_cnt    out  $clog2(WIDTH)    bits collected in the current partial word
// BEHAVIOUR
//   Reset (rst=0, async): shreg=0, bit_cnt=0, dout=0, out_valid=0, overrun=0.
//   Shift stage, per edge with shift=1:
//     - shreg <= {shreg[WIDTH-2:0], sin}
//     - bit_cnt increments; on the WIDTH-th bit it wraps to 0
//     - the WIDTH-th bit completes the word
//   shift=0: shreg and bit_cnt hold; gaps of any length between bits are legal.
//   Completed word = {shreg[WIDTH-2:0], sin}; first received bit lands in dout[WIDTH-1].
//   Latency: dout and out_valid update at the same edge that samples the last bit.
//     - No extra cycle.
//   Handshake: transfer occurs on an edge where out_valid=1 && out_ready=1.
//   Output register update, per edge:
//     - complete, and (out_valid=0 or transfer): dout <= word, out_valid <= 1
//     - complete, out_valid=1 and no transfer: word dropped
//       - dout and out_valid unchanged
//       - overrun <= 1
//     - no complete, transfer: out_valid <= 0; dout keeps its last value
//     - otherwise: hold
//   Simultaneous complete + transfer:
//     - new word loads; out_valid stays 1; no overrun
//   clr=1, synchronous, overrides shift:
//     - shreg=0, bit_cnt=0, overrun=0
//     - out_valid and dout unaffected; a transfer in the same cycle still takes effect
//     - a bit presented with shift=1 in the same cycle is discarded
//   Reset mid-word: partial word discarded; next sampled bit is the MSB of a new word.
//   overrun stays 1 until clr or reset; it never blocks reception.
//   out_valid is not a pulse; it holds until a transfer.
// TESTING
//   1. Assert rst=0 -> dout=0, out_valid=0, overrun=0, bit_cnt=0 with no clock edge.
//   2. out_ready=1; shift=1 for 4 cycles, sin=1,0,1,1
//      -> after 4th edge: dout=4'b1011, out_valid=1 for one cycle; bit_cnt=0.
//   3. Bits 1,1; shift=0 for 3 cycles; then bits 0,1
//      -> bit_cnt holds at 2 during the gap; dout=4'b1101 after last bit.
//   4. out_ready=0; send word 1010, then word 0110
//      -> dout stays 4'b1010, overrun=1; then out_ready=1 -> out_valid falls;
//         clr -> overrun=0.
//   5. out_ready=1 on the edge that completes 0101 while 1100 is pending
//      -> dout=4'b0101, out_valid stays 1, overrun=0.
//   6. Shift 2 bits, pulse rst, then bits 0,0,1,1
//      -> dout=4'b0011; repeat with clr instead of rst -> same dout.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer.
//   Collects WIDTH bits (MSB first) while shift=1 and publishes each completed
//   word on a registered output guarded by a valid/ready handshake. A word that
//   completes while the previous one is still unaccepted is dropped, and the
//   sticky overrun flag is raised.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   shift      sample sin on this edge
//   sin        serial data, MSB first
//   clr        sync clear of the partial word and overrun (overrides shift)
//   out_ready  consumer accepts dout while out_valid=1
//   dout       completed word, stable while out_valid=1
//   out_valid  dout holds an unaccepted word
//   overrun    sticky: a completed word was dropped
//   bit_cnt    bits collected in the current partial word
module sipo_deser #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift,
  input  logic                     sin,
  input  logic                     clr,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Only the WIDTH-1 most recent bits need storing; the final bit goes
  // straight from sin into the output register.
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             transfer;

  always_comb begin
    word     = {shreg, sin};
    complete = shift && !clr && (bit_cnt == LAST_CNT);
    transfer = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= word[WIDTH-2:0];
      bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (complete && (!out_valid || transfer)) begin
      dout      <= word;
      out_valid <= 1'b1;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (complete && out_valid && !transfer) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: table-driven bench for sipo_deser (WIDTH=4). Each row drives
// one clock of inputs and states the outputs expected after that edge; words
// expected to be handed over are queued and compared when the handshake fires.
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       shift;
  logic       sin;
  logic       clr;
  logic       out_ready;
  logic [3:0] dout;
  logic       out_valid;
  logic       overrun;
  logic [1:0] bit_cnt;

  int unsigned tests;
  int unsigned fails;

  logic [3:0] sbq[$];

  typedef struct {
    logic       sh;
    logic       sn;
    logic       cl;
    logic       rdy;
    logic [3:0] d;
    logic       v;
    logic       ov;
    logic [1:0] cnt;
    logic       push;
  } row_t;

  row_t rows[$];

  sipo_deser #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift     (shift),
    .sin       (sin),
    .clr       (clr),
    .out_ready (out_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(logic sh, logic sn, logic cl, logic rdy,
                              logic [3:0] d, logic v, logic ov,
                              logic [1:0] cnt, logic push);
    row_t r;
    r.sh = sh; r.sn = sn; r.cl = cl; r.rdy = rdy;
    r.d = d; r.v = v; r.ov = ov; r.cnt = cnt; r.push = push;
    return r;
  endfunction

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic apply(input row_t r, input int idx);
    logic [3:0] e;
    @(negedge clk);
    shift = r.sh; sin = r.sn; clr = r.cl; out_ready = r.rdy;
    #1;
    // A handshake on the coming edge hands dout to the consumer.
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected step %0d: got %0h expected no transfer", idx, dout);
      end else begin
        e = sbq.pop_front();
        check("sb_word", idx, 32'(dout), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    check("dout", idx, 32'(dout), 32'(r.d));
    check("out_valid", idx, 32'(out_valid), 32'(r.v));
    check("overrun", idx, 32'(overrun), 32'(r.ov));
    check("bit_cnt", idx, 32'(bit_cnt), 32'(r.cnt));
    if (r.push) sbq.push_back(r.d);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    shift = 1'b0; sin = 1'b0; clr = 1'b0; out_ready = 1'b0;

    // Reset with no clock edge yet.
    rst = 1'b0;
    #2;
    check("rst_dout", 0, 32'(dout), 32'h0);
    check("rst_valid", 0, 32'(out_valid), 32'h0);
    check("rst_overrun", 0, 32'(overrun), 32'h0);
    check("rst_cnt", 0, 32'(bit_cnt), 32'h0);
    #1 rst = 1'b1;

    //           sh  sn  cl  rdy dout     v   ov  cnt push
    // word 1011, accepted immediately
    rows.push_back(mk(1, 1, 0, 1, 4'b0000, 0, 0, 1, 0));
    rows.push_back(mk(1, 0, 0, 1, 4'b0000, 0, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b0000, 0, 0, 3, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b1011, 1, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 4'b1011, 0, 0, 0, 0));
    // 1,1, gap of 3, then 0,1 -> 1101
    rows.push_back(mk(1, 1, 0, 1, 4'b1011, 0, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b1011, 0, 0, 2, 0));
    rows.push_back(mk(0, 0, 0, 1, 4'b1011, 0, 0, 2, 0));
    rows.push_back(mk(0, 1, 0, 1, 4'b1011, 0, 0, 2, 0));
    rows.push_back(mk(0, 0, 0, 1, 4'b1011, 0, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 1, 4'b1011, 0, 0, 3, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b1101, 1, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 4'b1101, 0, 0, 0, 0));
    // 1010 held, 0110 dropped -> overrun; accept; clr
    rows.push_back(mk(1, 1, 0, 0, 4'b1101, 0, 0, 1, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1101, 0, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 0, 4'b1101, 0, 0, 3, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1010, 1, 0, 0, 1));
    rows.push_back(mk(1, 0, 0, 0, 4'b1010, 1, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 4'b1010, 1, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 0, 4'b1010, 1, 0, 3, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1010, 1, 1, 0, 0));
    rows.push_back(mk(0, 0, 0, 1, 4'b1010, 0, 1, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 4'b1010, 0, 0, 0, 0));
    // 1100 pending, 0101 completes on the accepting edge
    rows.push_back(mk(1, 1, 0, 0, 4'b1010, 0, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 4'b1010, 0, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1010, 0, 0, 3, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1100, 1, 0, 0, 1));
    rows.push_back(mk(1, 0, 0, 0, 4'b1100, 1, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 0, 4'b1100, 1, 0, 2, 0));
    rows.push_back(mk(1, 0, 0, 0, 4'b1100, 1, 0, 3, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b0101, 1, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 1, 4'b0101, 0, 0, 0, 0));
    // 2 bits, clr (with shift=1, bit discarded), then 0,0,1,1
    rows.push_back(mk(1, 1, 0, 1, 4'b0101, 0, 0, 1, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b0101, 0, 0, 2, 0));
    rows.push_back(mk(1, 1, 1, 1, 4'b0101, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 0, 1, 4'b0101, 0, 0, 1, 0));
    rows.push_back(mk(1, 0, 0, 1, 4'b0101, 0, 0, 2, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b0101, 0, 0, 3, 0));
    rows.push_back(mk(1, 1, 0, 1, 4'b0011, 1, 0, 0, 1));
    // clr together with a transfer: the transfer still happens
    rows.push_back(mk(0, 0, 1, 1, 4'b0011, 0, 0, 0, 0));

    for (int i = 0; i < rows.size(); i++) apply(rows[i], i + 1);

    // Reset mid-word: partial word discarded, output cleared asynchronously.
    apply(mk(1, 1, 0, 1, 4'b0011, 0, 0, 1, 0), 100);
    apply(mk(1, 1, 0, 1, 4'b0011, 0, 0, 2, 0), 101);
    @(negedge clk);
    shift = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_cnt", 102, 32'(bit_cnt), 32'h0);
    check("arst_dout", 102, 32'(dout), 32'h0);
    check("arst_valid", 102, 32'(out_valid), 32'h0);
    check("arst_overrun", 102, 32'(overrun), 32'h0);
    #2 rst = 1'b1;
    apply(mk(1, 0, 0, 1, 4'b0000, 0, 0, 1, 0), 103);
    apply(mk(1, 0, 0, 1, 4'b0000, 0, 0, 2, 0), 104);
    apply(mk(1, 1, 0, 1, 4'b0000, 0, 0, 3, 0), 105);
    apply(mk(1, 1, 0, 1, 4'b0011, 1, 0, 0, 1), 106);
    apply(mk(0, 0, 0, 1, 4'b0011, 0, 0, 0, 0), 107);

    check("sb_drained", 108, 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
